fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage sitting directly downstream of the program counter: drives the instruction-memory read request for the current `imemaddr`, tells the PC when to advance via `pc_wait`, and owns the IF/ID pipeline register consumed by decode. A one-entry skid buffer absorbs an instruction that returns while decode is stalled, so no fetch is repeated. Flush (branch/jump redirect) and halt are handled here.

## Interface
Parameters:
- `RESET_NPC`, 32'h0000_0000, value of `ifid_npc` after reset.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `imemaddr`  in  32 (`word_t`)  current PC from the pc block.
- `ihit`  in  1  instruction memory returns `imemload` this cycle.
- `imemload`  in  32 (`word_t`)  fetched instruction word.
- `stall`  in  1  decode cannot accept a new IF/ID value (hazard unit).
- `flush`  in  1  redirect in progress; discard wrong-path fetch.
- `halt`  in  1  halt decoded downstream; stop fetching permanently.
- `iREN`  out  1  instruction memory read enable.
- `pc_wait`  out  1  to pc block: 1 = hold PC, 0 = PC may update.
- `ifid_instr`  out  32  IF/ID instruction.
- `ifid_npc`  out  32  IF/ID next-PC (`imemaddr + 4`).
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `fetch_count`  out  32  instructions delivered to IF/ID.

## Operation
- States: FETCH, HELD (skid buffer full), HALTED. Priority per cycle: halt > flush > stall > normal.
- FETCH: `iREN`=1.
  - ihit, no stall/flush: IF/ID <= {imemload, imemaddr+4}, valid=1; `pc_wait`=0; stay.
  - ihit and stall: skid <= {imemload, imemaddr+4}; IF/ID held; `pc_wait`=0; -> HELD.
  - no ihit, no stall: IF/ID valid<=0, instr<=0 (bubble); `pc_wait`=1.
  - no ihit, stall: IF/ID held; `pc_wait`=1.
- HELD: `iREN`=0, `pc_wait`=1. When stall drops: IF/ID <= skid, valid=1; -> FETCH.
- flush (FETCH or HELD): IF/ID valid<=0, instr<=0 even if stall; skid discarded; any ihit word discarded; `pc_wait`=0 so PC loads redirect; -> FETCH.
- halt: -> HALTED next edge; IF/ID valid<=0, instr<=0. HALTED: `iREN`=0, `pc_wait`=1, IF/ID frozen; exit only via nRST.
- npc arithmetic: 32-bit modulo; `imemaddr`=0xFFFF_FFFC gives npc 0.
- `fetch_count` +1 on every edge writing valid=1 into IF/ID (direct or from skid); saturates at 0xFFFF_FFFF.

## Timing
- Reset (async, nRST=0): state FETCH, `ifid_instr`=0, `ifid_npc`=RESET_NPC, `ifid_valid`=0, `fetch_count`=0, skid empty; hence `iREN`=1, `pc_wait`=1 combinationally.
- `iREN`, `pc_wait` are combinational from state, `ihit`, `stall`, `flush`, `halt`; all IF/ID outputs and count registered.
- Latency: ihit in cycle N -> `ifid_valid`=1 after edge N (visible N+1) if unstalled; from HELD, one cycle after stall deasserts.
- Back-to-back ihit with no stall: one instruction per cycle, `pc_wait`=0 each cycle.
- Reset mid-HELD discards skid; mid-miss abandons request.

## Structure
- Add `fetch_state_t` enum {FETCH, HELD, HALTED} to `cpu_types_pkg`; reuse `word_t`.
- New `fetch_if.vh` interface with `fs` and `tb` modports, matching the pc interface style.
- Optional sub-module `fetch_skid_buf` (one-entry {instr, npc} register with full flag); otherwise single module.

## Test plan
- Reset: nRST=0 -> all IF/ID 0, npc=RESET_NPC, count 0, `iREN`=1, `pc_wait`=1.
- imemaddr=0x40, ihit=1, imemload=0x2002_0005 -> next cycle instr=0x2002_0005, npc=0x44, valid=1, count=1; `pc_wait`=0 in hit cycle.
- stall=1 with ihit, load=0xAAAA_0001 -> IF/ID unchanged, state HELD, `iREN`=0; release stall -> IF/ID=0xAAAA_0001, valid=1 next edge.
- flush with ihit and stall all =1 -> valid=0, word dropped, `pc_wait`=0, count unchanged.
- halt=1 -> HALTED, `iREN`=0, `pc_wait`=1 indefinitely; further ihit ignored.
- imemaddr=0xFFFF_FFFC hit -> npc=0; force count 0xFFFF_FFFF -> stays saturated.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: word type, FSM states, IF/ID payload.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HELD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // One IF/ID payload: the fetched word and the address after it.
    typedef struct packed {
        word_t instr;
        word_t npc;
    } ifid_t;

    localparam word_t NPC_STEP  = 32'd4;
    localparam word_t COUNT_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic word_t sat_inc(input word_t v);
        return (v == COUNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a fetched {instr, npc} while decode is stalled.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  i_load,
    input  logic  i_clear,
    input  ifid_t i_data,
    output ifid_t o_data,
    output logic  o_full
);

    ifid_t r_data;
    logic  r_full;

    // Capture on load, drop on clear; clear wins so a redirect always empties it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            // NOTE: state is updated with <= so every register samples pre-edge values.
            r_data <= i_data;
            r_full <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: imem request, PC hold control, IF/ID register, skid buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_NPC = 32'h0000_0000
)
(
    input  logic  CLK,
    input  logic  nRST,
    input  word_t imemaddr,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  stall,
    input  logic  flush,
    input  logic  halt,
    output logic  iREN,
    output logic  pc_wait,
    output word_t ifid_instr,
    output word_t ifid_npc,
    output logic  ifid_valid,
    output word_t fetch_count
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    ifid_t r_ifid;
    logic  r_valid;
    word_t r_fetch_count;

    ifid_t w_fetch_entry;
    ifid_t w_skid_data;
    ifid_t w_deliver_data;
    logic  w_skid_full;
    logic  w_skid_load;
    logic  w_skid_clear;
    logic  w_deliver;
    logic  w_bubble;

    // npc wraps modulo 2^32, so 0xFFFF_FFFC yields 0.
    assign w_fetch_entry = '{instr: imemload, npc: imemaddr + NPC_STEP};

    fetch_skid_buf u_skid (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_fetch_entry),
        .o_data  (w_skid_data),
        .o_full  (w_skid_full)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    // Next state: halt beats flush beats stall.
    always_comb begin
        // NOTE: default first so no path through the case leaves a latch behind.
        w_next_state = r_state;
        case (r_state)
            FETCH: begin
                if (halt)               w_next_state = HALTED;
                else if (flush)         w_next_state = FETCH;
                else if (ihit && stall) w_next_state = HELD;
            end
            HELD: begin
                if (halt)        w_next_state = HALTED;
                else if (flush)  w_next_state = FETCH;
                else if (!stall) w_next_state = FETCH;
            end
            HALTED:  w_next_state = HALTED;
            default: w_next_state = FETCH;
        endcase
    end

    // Outputs and IF/ID / skid write actions for the current cycle.
    always_comb begin
        iREN           = 1'b0;
        pc_wait        = 1'b1;
        w_deliver      = 1'b0;
        w_deliver_data = w_fetch_entry;
        w_bubble       = 1'b0;
        w_skid_load    = 1'b0;
        w_skid_clear   = 1'b0;
        case (r_state)
            FETCH: begin
                iREN = !halt;
                if (halt) begin
                    w_bubble     = 1'b1;
                    w_skid_clear = 1'b1;
                end else if (flush) begin
                    pc_wait      = 1'b0;
                    w_bubble     = 1'b1;
                    w_skid_clear = 1'b1;
                end else if (ihit) begin
                    pc_wait = 1'b0;
                    if (stall) w_skid_load = 1'b1;
                    else       w_deliver   = 1'b1;
                end else if (!stall) begin
                    w_bubble = 1'b1;
                end
            end
            HELD: begin
                if (halt) begin
                    w_bubble     = 1'b1;
                    w_skid_clear = 1'b1;
                end else if (flush) begin
                    pc_wait      = 1'b0;
                    w_bubble     = 1'b1;
                    w_skid_clear = 1'b1;
                end else if (!stall && w_skid_full) begin
                    w_deliver      = 1'b1;
                    w_deliver_data = w_skid_data;
                    w_skid_clear   = 1'b1;
                end
            end
            default: begin
                iREN    = 1'b0;
                pc_wait = 1'b1;
            end
        endcase
    end

    // IF/ID register and delivered-instruction counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ifid        <= '{instr: '0, npc: RESET_NPC};
            r_valid       <= 1'b0;
            r_fetch_count <= '0;
        end else if (w_deliver) begin
            r_ifid        <= w_deliver_data;
            r_valid       <= 1'b1;
            r_fetch_count <= sat_inc(r_fetch_count);
        end else if (w_bubble) begin
            r_ifid.instr  <= '0;
            r_valid       <= 1'b0;
        end
    end

    assign ifid_instr  = r_ifid.instr;
    assign ifid_npc    = r_ifid.npc;
    assign ifid_valid  = r_valid;
    assign fetch_count = r_fetch_count;

endmodule
